// File: rtl/sketch_issue_ctrl.sv
// Round-robin issue front-end for the count-min sketch, with epoch counting
// and the stop / drain / clear sequencing of the sketch counters.
module sketch_issue_ctrl #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_SIZE    = 22,
  parameter int unsigned SKETCH_LAT   = 5,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned EPOCH_W      = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [EPOCH_W-1:0]                  epoch_len,
  input  logic                                clear_req,
  output logic                                sk_valid,
  output logic [ADDR_SIZE-1:0]                sk_addr,
  output logic                                sk_query_rst_n,
  output logic                                busy,
  output logic                                clear_done,
  output logic [7:0]                          epoch_id,
  output logic [31:0]                         issue_cnt
);

  localparam int unsigned LG_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (SKETCH_LAT > CLEAR_CYCLES) ? SKETCH_LAT : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]           state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [LG_W-1:0]      last_grant, last_grant_d;
  logic [EPOCH_W-1:0]   epoch_cnt, epoch_cnt_d;
  logic [31:0]          issue_cnt_d;
  logic [7:0]           epoch_id_d;
  logic                 sk_valid_d;
  logic [ADDR_SIZE-1:0] sk_addr_d;
  logic                 grant_vld;
  logic [LG_W-1:0]      grant_idx;
  logic                 trigger;

  assign trigger = clear_req || ((epoch_len != '0) && (epoch_cnt >= epoch_len));

  // Round-robin pick: nearest asserted requester after last_grant (descending scan, nearest wins)
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = last_grant;
    idx       = 0;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      idx = (32'(last_grant) + 32'(k)) % NUM_REQ;
      if (req_valid[LG_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = LG_W'(idx);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    last_grant_d = last_grant;
    epoch_cnt_d  = epoch_cnt;
    issue_cnt_d  = issue_cnt;
    epoch_id_d   = epoch_id;
    sk_valid_d   = 1'b0;
    sk_addr_d    = sk_addr;
    req_ready    = '0;
    case (state)
      ST_RUN: begin
        if (trigger) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(SKETCH_LAT);
        end else if (grant_vld) begin
          req_ready    = NUM_REQ'(1) << grant_idx;
          last_grant_d = grant_idx;
          epoch_cnt_d  = (epoch_cnt == '1) ? epoch_cnt : epoch_cnt + EPOCH_W'(1);
          issue_cnt_d  = issue_cnt + 32'd1;
          sk_valid_d   = 1'b1;
          sk_addr_d    = req_addr[grant_idx];
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d = ST_CLEAR;
          cnt_d   = CNT_W'(CLEAR_CYCLES);
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d     = ST_RUN;
          epoch_cnt_d = '0;
          epoch_id_d  = epoch_id + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and registered outputs; status flags follow the next state so they are flop-driven
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      cnt            <= '0;
      last_grant     <= LG_W'(NUM_REQ - 1);
      epoch_cnt      <= '0;
      issue_cnt      <= '0;
      epoch_id       <= '0;
      sk_valid       <= 1'b0;
      sk_addr        <= '0;
      sk_query_rst_n <= 1'b1;
      busy           <= 1'b0;
      clear_done     <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      last_grant     <= last_grant_d;
      epoch_cnt      <= epoch_cnt_d;
      issue_cnt      <= issue_cnt_d;
      epoch_id       <= epoch_id_d;
      sk_valid       <= sk_valid_d;
      sk_addr        <= sk_addr_d;
      sk_query_rst_n <= (state_d != ST_CLEAR);
      busy           <= (state_d != ST_RUN);
      clear_done     <= (state == ST_CLEAR) && (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_sketch_issue_ctrl.sv
// Bench for sketch_issue_ctrl: directed table, hand sequences for the clear
// corner cases, then random traffic against a timestamp-based reference model.
module tb_sketch_issue_ctrl;

  localparam int N  = 4;
  localparam int AW = 22;
  localparam int SL = 5;
  localparam int CC = 4;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0]         req_ready;
  logic [31:0]          epoch_len;
  logic                 clear_req;
  logic                 sk_valid;
  logic [AW-1:0]        sk_addr;
  logic                 sk_query_rst_n;
  logic                 busy;
  logic                 clear_done;
  logic [7:0]           epoch_id;
  logic [31:0]          issue_cnt;

  sketch_issue_ctrl #(
    .NUM_REQ(N), .ADDR_SIZE(AW), .SKETCH_LAT(SL), .CLEAR_CYCLES(CC), .EPOCH_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .epoch_len(epoch_len), .clear_req(clear_req),
    .sk_valid(sk_valid), .sk_addr(sk_addr), .sk_query_rst_n(sk_query_rst_n),
    .busy(busy), .clear_done(clear_done), .epoch_id(epoch_id), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: clear progress is tracked by the cycle number of the trigger
  int          m_cyc, m_trig, m_last;
  bit          m_active, m_skv, m_cd;
  logic [AW-1:0] m_ska;
  logic [31:0] m_epoch, m_issue;
  logic [7:0]  m_id;

  logic [N-1:0] obs_rdy;
  logic         obs_busy, obs_qr, obs_cd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cyc = 0; m_trig = 0; m_last = N - 1; m_active = 0; m_skv = 0; m_cd = 0;
    m_ska = '0; m_epoch = '0; m_issue = '0; m_id = '0;
  endtask

  // One clock cycle: drive at negedge, compare just after, then advance the model
  task automatic cycle(input logic [N-1:0] v, input logic clr, input logic [31:0] el);
    logic [N-1:0] exp_rdy;
    bit trig;
    int gidx;
    @(negedge clk);
    req_valid = v; clear_req = clr; epoch_len = el;
    for (int i = 0; i < N; i++) req_addr[i] = AW'($urandom());
    #1;
    exp_rdy = '0; trig = 0; gidx = -1;
    if (!m_active) begin
      trig = clr || (el != 0 && m_epoch >= el);
      if (!trig) begin
        for (int k = 1; k <= N; k++) begin
          if (gidx < 0 && v[(m_last + k) % N]) gidx = (m_last + k) % N;
        end
        if (gidx >= 0) exp_rdy[gidx] = 1'b1;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("sk_valid", 64'(sk_valid), 64'(m_skv));
    if (m_skv) chk("sk_addr", 64'(sk_addr), 64'(m_ska));
    chk("busy", 64'(busy), 64'(m_active));
    chk("sk_query_rst_n", 64'(sk_query_rst_n), 64'(!(m_active && (m_cyc - m_trig) > SL)));
    chk("clear_done", 64'(clear_done), 64'(m_cd));
    chk("epoch_id", 64'(epoch_id), 64'(m_id));
    chk("issue_cnt", 64'(issue_cnt), 64'(m_issue));
    obs_rdy = req_ready; obs_busy = busy; obs_qr = sk_query_rst_n; obs_cd = clear_done;
    m_skv = (gidx >= 0);
    if (gidx >= 0) begin
      m_ska   = req_addr[gidx];
      m_last  = gidx;
      m_epoch = (m_epoch == '1) ? m_epoch : m_epoch + 1;
      m_issue = m_issue + 1;
    end
    if (trig) begin m_active = 1; m_trig = m_cyc; end
    m_cyc++;
    m_cd = 0;
    if (m_active && (m_cyc - m_trig) == SL + CC + 1) begin
      m_active = 0; m_epoch = '0; m_id = m_id + 1; m_cd = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; clear_req = 1'b0; epoch_len = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_sk_valid", 64'(sk_valid), 64'(0));
    chk("rst_sk_addr", 64'(sk_addr), 64'(0));
    chk("rst_qr", 64'(sk_query_rst_n), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_clear_done", 64'(clear_done), 64'(0));
    chk("rst_epoch_id", 64'(epoch_id), 64'(0));
    chk("rst_issue_cnt", 64'(issue_cnt), 64'(0));
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic [31:0]  exp_issue;
    logic         exp_skv;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int g, lows, qrl, busy_n;
    bit done, clr;
    logic [31:0] el;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; clear_req = 1'b0; epoch_len = '0;
    model_reset();

    // All four valid rotate 0..3, then only ports 1 and 3 alternate with no idle cycle
    tbl[0]  = '{4'hF, 4'b0001, 32'd0,  1'b0};
    tbl[1]  = '{4'hF, 4'b0010, 32'd1,  1'b1};
    tbl[2]  = '{4'hF, 4'b0100, 32'd2,  1'b1};
    tbl[3]  = '{4'hF, 4'b1000, 32'd3,  1'b1};
    tbl[4]  = '{4'hF, 4'b0001, 32'd4,  1'b1};
    tbl[5]  = '{4'hF, 4'b0010, 32'd5,  1'b1};
    tbl[6]  = '{4'hF, 4'b0100, 32'd6,  1'b1};
    tbl[7]  = '{4'hF, 4'b1000, 32'd7,  1'b1};
    tbl[8]  = '{4'hA, 4'b0010, 32'd8,  1'b1};
    tbl[9]  = '{4'hA, 4'b1000, 32'd9,  1'b1};
    tbl[10] = '{4'hA, 4'b0010, 32'd10, 1'b1};
    tbl[11] = '{4'hA, 4'b1000, 32'd11, 1'b1};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, 1'b0, 32'd0);
      chk($sformatf("tbl%0d_ready", i), 64'(obs_rdy), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_issue", i), 64'(issue_cnt), 64'(tbl[i].exp_issue));
      chk($sformatf("tbl%0d_skv", i), 64'(sk_valid), 64'(tbl[i].exp_skv));
    end

    // One-cycle clear_req with a pending request, second pulse during DRAIN ignored
    cycle(4'b0001, 1'b1, 32'd0);
    chk("clr_no_grant", 64'(obs_rdy), 64'(0));
    busy_n = 0; done = 0;
    for (int k = 1; k < 20; k++) begin
      cycle(4'b0001, (k == 2), 32'd0);
      if (obs_cd) begin done = 1; break; end
      if (obs_busy) busy_n++;
    end
    chk("clr_done_seen", 64'(done), 64'(1));
    chk("clr_busy_cycles", 64'(busy_n), 64'(9));
    chk("clr_epoch_id", 64'(epoch_id), 64'(1));
    chk("clr_resume_grant", 64'(obs_rdy), 64'(1));
    repeat (12) cycle(4'b0001, 1'b0, 32'd0);
    chk("clr_single", 64'(epoch_id), 64'(1));

    // epoch_len = 3 auto-clear from a fresh reset
    do_reset();
    g = 0; lows = 0; qrl = 0; done = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(4'b0001, 1'b0, 32'd3);
      if (obs_cd) begin done = 1; break; end
      if (obs_rdy != 0 && lows == 0) g++;
      else lows++;
      if (!obs_qr) qrl++;
    end
    chk("ep_done_seen", 64'(done), 64'(1));
    chk("ep_grants", 64'(g), 64'(3));
    chk("ep_ready_low", 64'(lows), 64'(1 + SL + CC));
    chk("ep_qr_low", 64'(qrl), 64'(CC));
    chk("ep_resume_grant", 64'(obs_rdy), 64'(1));
    chk("ep_epoch_id", 64'(epoch_id), 64'(1));

    // clear_req coinciding with expiry gives one clear; epoch restarts from 0
    done = 0;
    for (int k = 0; k < 40; k++) begin
      clr = (!m_active && m_epoch >= 3);
      cycle(4'b0001, clr, 32'd3);
      if (obs_cd) begin done = 1; break; end
    end
    chk("coinc_done_seen", 64'(done), 64'(1));
    chk("coinc_epoch_id", 64'(epoch_id), 64'(2));
    g = (obs_rdy != 0) ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      cycle(4'b0001, 1'b0, 32'd3);
      if (obs_rdy == 0) break;
      g++;
    end
    chk("coinc_next_grants", 64'(g), 64'(3));

    // Random traffic, occasional clear_req and epoch_len changes
    el = 32'd0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) el = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      cycle(N'($urandom()), ($urandom_range(0, 39) == 0), el);
    end

    // Reset asserted mid-CLEAR
    done = 0;
    cycle(4'hF, 1'b1, 32'd0);
    for (int k = 0; k < 20; k++) begin
      cycle(4'hF, 1'b0, 32'd0);
      if (!obs_qr) begin done = 1; break; end
    end
    chk("mid_clear_reached", 64'(done), 64'(1));
    @(negedge clk);
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_qr", 64'(sk_query_rst_n), 64'(1));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_epoch_id", 64'(epoch_id), 64'(0));
    chk("async_issue_cnt", 64'(issue_cnt), 64'(0));
    chk("async_sk_valid", 64'(sk_valid), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'hF, 1'b0, 32'd0);
    chk("post_rst_port0", 64'(obs_rdy), 64'(1));
    cycle(4'hF, 1'b0, 32'd0);
    chk("post_rst_port1", 64'(obs_rdy), 64'(2));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sketch_issue_ctrl.md
# sketch_issue_ctrl

Front-end controller for the count-min sketch datapath. It arbitrates up to NUM_REQ address streams round-robin into the sketch's single-issue input port, at one update per cycle. It counts updates per epoch and sequences the epoch clear: stop issue, drain the sketch pipeline, then pulse the sketch's query_rst_n low. It sits between the per-channel address capture logic and the hash and sketch pipeline.

## Interface
Parameters:
- NUM_REQ, 4, number of requester ports (≥2)
- ADDR_SIZE, 22, address width, equal to the sketch's ADDR_SIZE
- SKETCH_LAT, 5, cycles from sk_valid to the sketch result; sets the drain length (≥1)
- CLEAR_CYCLES, 4, cycles sk_query_rst_n is held low (≥1)
- EPOCH_W, 32, width of epoch_len and of the epoch counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  [NUM_REQ]  requester i has an address
- req_addr  in  [NUM_REQ][ADDR_SIZE]  requester addresses
- req_ready  out  [NUM_REQ]  grant; handshake completes when valid&&ready
- epoch_len  in  EPOCH_W  updates per epoch; 0 disables auto-clear
- clear_req  in  1  software clear request, level-sampled
- sk_valid  out  1  update to sketch
- sk_addr  out  ADDR_SIZE  update address
- sk_query_rst_n  out  1  sketch counter clear, active-low
- busy  out  1  high while in DRAIN or CLEAR
- clear_done  out  1  one-cycle pulse on return to RUN
- epoch_id  out  8  completed-clear count, wraps
- issue_cnt  out  32  total accepted updates, wraps

## Operation
- The FSM has three states: RUN, DRAIN and CLEAR. Reset enters RUN.
- Trigger = clear_req || (epoch_len != 0 && epoch_cnt >= epoch_len).
- RUN with trigger = 0:
  - Round-robin grant among asserted req_valid. Search starts at last_grant+1 and wraps modulo NUM_REQ.
  - req_ready is combinational from req_valid and state. At most one bit is high.
  - On a grant: last_grant ← index, epoch_cnt += 1, issue_cnt += 1.
  - After reset, last_grant = NUM_REQ-1, so port 0 has first priority.
- RUN with trigger = 1:
  - req_ready is all zero and no grant occurs that cycle.
  - Next state is DRAIN. The drain counter loads SKETCH_LAT.
- DRAIN: no grants. Decrement each cycle. Go to CLEAR after SKETCH_LAT cycles. The counter loads CLEAR_CYCLES.
- CLEAR: no grants. sk_query_rst_n = 0. Go to RUN after CLEAR_CYCLES cycles. On that transition: epoch_cnt ← 0, epoch_id += 1, and clear_done is high in the first RUN cycle.
- clear_req while in DRAIN or CLEAR is ignored. No second clear is queued. Software must deassert clear_req by the time clear_done pulses, otherwise a new clear starts.
- Simultaneous clear_req and epoch expiry cause a single clear.
- A change to epoch_len mid-epoch takes effect immediately. If the new value is ≤ epoch_cnt and non-zero, the epoch expires on the next RUN cycle.
- busy = (state != RUN).
- epoch_cnt saturates at all-ones and does not wrap. issue_cnt and epoch_id wrap.

## Timing
- Reset values:
  - req_ready = 0, sk_valid = 0, sk_addr = 0
  - sk_query_rst_n = 1, busy = 0, clear_done = 0
  - epoch_id = 0, issue_cnt = 0, epoch_cnt = 0
  - last_grant = NUM_REQ-1, state = RUN
- sk_valid and sk_addr are registered. A handshake in cycle t gives sk_valid = 1 with the granted address in cycle t+1. sk_valid = 0 otherwise.
- sk_query_rst_n, busy and clear_done are flop-driven and glitch-free.
- Trigger in RUN cycle t gives:
  - DRAIN in cycles t+1 .. t+SKETCH_LAT
  - CLEAR, with sk_query_rst_n low, in cycles t+SKETCH_LAT+1 .. t+SKETCH_LAT+CLEAR_CYCLES
  - RUN with clear_done = 1 in cycle t+SKETCH_LAT+CLEAR_CYCLES+1; grants are allowed in that cycle
- The last sk_valid before a clear lands in cycle t, at the latest. Its sketch result completes before sk_query_rst_n falls.
- Throughput is one update per cycle in RUN.
- Asynchronous reset mid-DRAIN or mid-CLEAR returns immediately to RUN with the reset values. sk_query_rst_n goes high asynchronously.

## Test plan
- Reset, all four requesters held valid, epoch_len = 0 → grants in order 0,1,2,3,0,…. sk_addr follows one cycle later. issue_cnt = 8 after 8 cycles.
- Only ports 1 and 3 valid → grants alternate 1,3,1,3. Ports 0 and 2 never see ready. No idle cycles.
- epoch_len = 3, port 0 continuously valid → 3 grants, then ready low for 1+5+4 cycles. sk_query_rst_n is low for exactly 4 cycles, then clear_done = 1, epoch_id = 1 and grants resume.
- clear_req pulsed for 1 cycle in RUN with a request pending → no grant in that cycle. busy stays high for 9 cycles. A second clear_req pulse during DRAIN causes no extra clear (epoch_id increments by exactly 1).
- clear_req and epoch expiry in the same cycle → exactly one clear sequence. epoch_cnt = 0 afterwards.
- rst_n asserted during CLEAR → sk_query_rst_n = 1 and state RUN immediately, all counters 0. After release, port 0 gets the first grant.
